instr_enc: RTL and testbench
============================

# instr_enc

Instruction encoder and loader: the inverse of the control-unit decode. Accepts control words in the same 11-bit format the control unit produces (5 control bits + 6-bit ALU function), plus register and immediate fields. Assembles the matching 32-bit MIPS instruction word for each one and writes the words sequentially into instruction memory. It sits on the bench/boot side of the CPU and preloads instruction memory before the core runs.

## Interface
- ADDR_W, 8, instruction memory word-address width; capacity is 2**ADDR_W words.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- start  in  1  pulse; restart loading at address 0
- flush  in  1  pad remainder with NOPs; honoured only with ENC_NOP_PAD_EN
- in_valid  in  1  control word present
- in_ready  out  1  encoder accepts this cycle
- in_signal  in  11  {ctrl[4:0], func[5:0]}, control-unit format
- in_rs  in  5  rs field / base register
- in_rt  in  5  rt field / load-store data register
- in_rd  in  5  rd field, R-type only
- in_shamt  in  5  shamt field, R-type only
- in_imm  in  16  immediate / offset, I-type only
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since start
- busy  out  1  state is RUN or PAD
- full  out  1  memory filled
- err  out  1  sticky: an illegal control word was seen

## Operation
- States: IDLE, RUN, PAD, FULL. Reset puts the block in IDLE.
- Any state, start=1: next state RUN; count, err and the address pointer clear to 0.
- in_ready = (state==RUN) & !start & !flush. An input is accepted when in_valid & in_ready.
- Encoding of an accepted word, with ctrl = in_signal[10:6] and func = in_signal[5:0]:
  - ctrl 00011: R-type word {6'b000000, rs, rt, rd, shamt, func}.
  - ctrl 00101 selects an I-type word {op, rs, rt, imm}. func maps to op as follows: 100000 → 001000 (ADDI), 100001 → 001001 (ADDIU), 100100 → 001100 (ANDI), 100101 → 001101 (ORI), 100110 → 001110 (XORI), 101010 → 001010 (SLTI), 101011 → 001011 (SLTIU).
  - ctrl 10101 with func 100000: op 100011 (LW).
  - ctrl 01100 or 01110 with func 100000: op 101011 (SW).
  - in_signal == 0: NOP, word 32'h0.
  - Anything else is illegal. err is set, nothing is written, and the handshake still completes.
- Every legal word is written to the pointer address, then the pointer and count increment.
- RUN → FULL when the write that makes count == 2**ADDR_W is issued. In FULL, in_ready=0 and full=1 until start or reset.
- RUN with flush=1 (macro enabled): go to PAD. PAD writes 32'h0 once per cycle until full, then goes to FULL. flush in FULL, PAD or IDLE is ignored.

## Timing
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, count 0, busy 0, full 0, err 0.
- Latency 1: an input accepted at edge N drives imem_we=1 with registered imem_addr/imem_wdata during cycle N+1. imem_we is a single-cycle pulse per word.
- count and full update on the same edge that registers the write. full is asserted in the same cycle as the final imem_we.
- Throughput: one word per cycle in RUN and in PAD.
- start together with in_valid: start wins and the input is not accepted. A write already registered from the previous edge still completes.
- Reset asserted mid-load aborts immediately. Memory contents already written are left as they are.
- err is updated on the acceptance edge and stays set until start or reset.

## Configuration
- ENC_NOP_PAD_EN defined: flush drives RUN → PAD, which zero-fills the remaining words and ends in FULL.
- ENC_NOP_PAD_EN undefined: the PAD state is not built. flush has no effect and is excluded from in_ready; the port stays present.

## Test plan
- Reset, start, then send 11'b00011_100000 with rs=1, rt=2, rd=3 → imem_wdata 32'h00221820 at addr 0, count=1.
- Send ADDI control 11'b00101_100000 with rs=0, rt=8, imm=16'h0005 → word 32'h20080005 one cycle after acceptance.
- Send SW control 11'b01100_100000 with rs=29, rt=31, imm=4, then 11'b11111_000000 → first word 32'hAFBF0004. The second sets err=1, produces no imem_we, and leaves count unchanged.
- With ADDR_W=2, stream 4 back-to-back words → writes at addresses 0..3. full=1 on the 4th write, then in_ready=0; a 5th in_valid is held unaccepted.
- With ENC_NOP_PAD_EN, ADDR_W=3: write 2 words, then pulse flush → 6 consecutive zero writes at addresses 2..7, then FULL with count=8.
- Drop rst_n mid-stream → all outputs go to 0 immediately. After release, in_ready stays 0 until start.

Source files
------------

// File: rtl/instr_enc.sv
// Instruction encoder/loader: turns control-unit words back into MIPS instructions
// and streams them into instruction memory. Optional NOP padding via ENC_NOP_PAD_EN.
module instr_enc #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       in_signal,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PAD  = 2'b10,
        ST_FULL = 2'b11
    } state_e;

    // count value of the last free slot; writing it fills the memory
    localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

    // Returns {legal, word} for one control word plus its operand fields.
    function automatic logic [32:0] encode_word(
        input logic [10:0] sig,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [15:0] imm
    );
        logic [4:0]  ctrl;
        logic [5:0]  func;
        logic [5:0]  op;
        logic        legal;
        logic [32:0] res;
        ctrl  = sig[10:6];
        func  = sig[5:0];
        op    = 6'b000000;
        legal = 1'b0;
        res   = 33'd0;
        case (ctrl)
            5'b00011: res = {1'b1, 6'b000000, rs, rt, rd, shamt, func};
            5'b00101: begin
                legal = 1'b1;
                case (func)
                    6'b100000: op = 6'b001000;
                    6'b100001: op = 6'b001001;
                    6'b100100: op = 6'b001100;
                    6'b100101: op = 6'b001101;
                    6'b100110: op = 6'b001110;
                    6'b101010: op = 6'b001010;
                    6'b101011: op = 6'b001011;
                    default:   legal = 1'b0;
                endcase
                res = {legal, op, rs, rt, imm};
            end
            5'b10101: res = {(func == 6'b100000), 6'b100011, rs, rt, imm};
            5'b01100,
            5'b01110: res = {(func == 6'b100000), 6'b101011, rs, rt, imm};
            5'b00000: res = {(func == 6'b000000), 32'h0000_0000};
            default:  res = 33'd0;
        endcase
        return res;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [32:0]       enc_s;
    logic              in_ready_s;
    logic              accept_s;

`ifdef ENC_NOP_PAD_EN
    assign in_ready_s = (state_q == ST_RUN) & ~start & ~flush;
`else
    logic flush_unused_s;
    assign flush_unused_s = flush;
    assign in_ready_s     = (state_q == ST_RUN) & ~start;
`endif

    assign enc_s    = encode_word(in_signal, in_rs, in_rt, in_rd, in_shamt, in_imm);
    assign accept_s = in_valid & in_ready_s;

    // Next-state, pointer/count and write-port logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (start) begin
            state_d = ST_RUN;
            ptr_d   = {ADDR_W{1'b0}};
            count_d = {(ADDR_W+1){1'b0}};
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept_s) begin
                        if (enc_s[32]) begin
                            we_d    = 1'b1;
                            addr_d  = ptr_q;
                            wdata_d = enc_s[31:0];
                            ptr_d   = ptr_q + ADDR_W'(1);
                            count_d = count_q + (ADDR_W+1)'(1);
                            if (count_q == LAST_CNT) begin
                                state_d = ST_FULL;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
`ifdef ENC_NOP_PAD_EN
                    else if (flush) begin
                        state_d = ST_PAD;
                    end
`endif
                    else begin
                        state_d = ST_RUN;
                    end
                end
`ifdef ENC_NOP_PAD_EN
                ST_PAD: begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = 32'h0000_0000;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    count_d = count_q + (ADDR_W+1)'(1);
                    if (count_q == LAST_CNT) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_PAD;
                    end
                end
`endif
                ST_IDLE: state_d = ST_IDLE;
                ST_FULL: state_d = ST_FULL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= {ADDR_W{1'b0}};
            count_q <= {(ADDR_W+1){1'b0}};
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign err        = err_q;
    assign busy       = (state_q == ST_RUN) | (state_q == ST_PAD);
    assign full       = (state_q == ST_FULL);

endmodule

// File: tb/tb_instr_enc.sv
// Scoreboard bench for instr_enc with an 8-word memory; NOP padding is
// exercised when ENC_NOP_PAD_EN is defined, flush-is-ignored otherwise.
module tb_instr_enc;
    localparam int AW        = 3;
    localparam int LAST_ADDR = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, start, flush, in_valid;
    logic          in_ready;
    logic [10:0]   in_signal;
    logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
    logic [15:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          busy, full, err;

    int          total = 0;
    int          bad = 0;
    int          exp_ptr = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_e;

    always #5 clk = ~clk;

    instr_enc #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_signal(in_signal),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .busy(busy), .full(full),
        .err(err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] word);
        sb_q.push_back({32'(exp_ptr & LAST_ADDR), word});
        exp_ptr++;
    endtask

    task automatic send(input logic [10:0] sig, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic legal, input logic [31:0] word);
        int waited;
        @(negedge clk);
        in_valid = 1'b1; in_signal = sig; in_rs = rs; in_rt = rt;
        in_rd = rd; in_shamt = sh; in_imm = imm;
        waited = 0;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check_val("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            if (legal) push_exp(word);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        exp_ptr = 0;
    endtask

    // Every write must match the oldest expected word; full only with the last slot.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_we", 64'(imem_we), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("wr_addr", 64'(imem_addr), {32'd0, mon_e[63:32]});
                check_val("wr_data", 64'(imem_wdata), {32'd0, mon_e[31:0]});
                check_val("full_on_last", 64'(full), 64'(mon_e[63:32] == LAST_ADDR));
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_signal = 11'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
        in_shamt = 5'd0; in_imm = 16'd0;
        #12;
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        check_val("rst_we", 64'(imem_we), 64'd0);
        check_val("rst_addr", 64'(imem_addr), 64'd0);
        check_val("rst_wdata", 64'(imem_wdata), 64'd0);
        check_val("rst_count", 64'(count), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_full", 64'(full), 64'd0);
        check_val("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        #1 check_val("idle_not_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;

        // basic encodings and an illegal word
        pulse_start();
        check_val("busy_run", 64'(busy), 64'd1);
        send(11'b00011_100000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 1'b1, 32'h0022_1820);
        check_val("count_1", 64'(count), 64'd1);
        send(11'b00101_100000, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 1'b1, 32'h2008_0005);
        send(11'b01100_100000, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0004, 1'b1, 32'hAFBF_0004);
        send(11'b11111_000000, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1111, 1'b0, 32'h0);
        check_val("err_set", 64'(err), 64'd1);
        check_val("count_illegal", 64'(count), 64'd3);
        send(11'b00101_000000, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0001, 1'b0, 32'h0);
        send(11'b10101_100001, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0001, 1'b0, 32'h0);
        check_val("count_illegal2", 64'(count), 64'd3);
        check_val("err_sticky", 64'(err), 64'd1);

        // fill the memory back-to-back
        pulse_start();
        check_val("err_cleared", 64'(err), 64'd0);
        check_val("count_cleared", 64'(count), 64'd0);
        send(11'b00011_100000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 1'b1, 32'h0022_1820);
        send(11'b00101_100000, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 1'b1, 32'h2008_0005);
        send(11'b01100_100000, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0004, 1'b1, 32'hAFBF_0004);
        send(11'b00000_000000, 5'd7, 5'd7, 5'd7, 5'd7, 16'h7777, 1'b1, 32'h0000_0000);
        send(11'b10101_100000, 5'd5, 5'd6, 5'd0, 5'd0, 16'hFFFC, 1'b1, 32'h8CA6_FFFC);
        send(11'b00101_100101, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 1'b1, 32'h3422_1234);
        send(11'b01110_100000, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0008, 1'b1, 32'hAC43_0008);
        send(11'b00011_000000, 5'd0, 5'd4, 5'd5, 5'd2, 16'h0000, 1'b1, 32'h0004_2880);
        check_val("count_full", 64'(count), 64'd8);
        check_val("full_set", 64'(full), 64'd1);
        check_val("busy_full", 64'(busy), 64'd0);
        @(negedge clk);
        in_valid = 1'b1; in_signal = 11'b00101_101011; in_rs = 5'd7; in_rt = 5'd9; in_imm = 16'h00FF;
        for (int i = 0; i < 4; i++) begin
            #1 check_val("held_in_full", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_val("count_held", 64'(count), 64'd8);

        // start wins over a simultaneous in_valid
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1;
        #1 check_val("ready_vs_start", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 start = 1'b0; in_valid = 1'b0; exp_ptr = 0;
        check_val("start_count0", 64'(count), 64'd0);
        check_val("start_full0", 64'(full), 64'd0);
        send(11'b00101_101011, 5'd7, 5'd9, 5'd0, 5'd0, 16'h00FF, 1'b1, 32'h2CE9_00FF);
        send(11'b00101_100000, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 1'b1, 32'h2008_0005);
`ifdef ENC_NOP_PAD_EN
        @(negedge clk);
        flush = 1'b1;
        for (int i = 0; i < 6; i++) push_exp(32'h0000_0000);
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_val("pad_not_yet_full", 64'(full), 64'd0);
        @(posedge clk);
        #1 check_val("pad_full", 64'(full), 64'd1);
        check_val("pad_count", 64'(count), 64'd8);
`else
        flush = 1'b1;
        send(11'b00011_100000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 1'b1, 32'h0022_1820);
        flush = 1'b0;
        check_val("flush_ignored", 64'(count), 64'd3);
`endif

        // asynchronous reset in the middle of a write
        pulse_start();
        send(11'b10101_100000, 5'd5, 5'd6, 5'd0, 5'd0, 16'hFFFC, 1'b1, 32'h8CA6_FFFC);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_we", 64'(imem_we), 64'd0);
        check_val("mid_rst_addr", 64'(imem_addr), 64'd0);
        check_val("mid_rst_wdata", 64'(imem_wdata), 64'd0);
        check_val("mid_rst_count", 64'(count), 64'd0);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_err", 64'(err), 64'd0);
        sb_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check_val("post_rst_not_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        pulse_start();
        send(11'b00101_100101, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 1'b1, 32'h3422_1234);
        repeat (2) @(negedge clk);
        check_val("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
